// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
//
// Round-robin arbiter that shares one valid/ready memory-style bus among
// NUM_REQ requesters. One transaction is in flight at a time: the winner is
// accepted in IDLE, issued downstream in ISSUE, and answered with a one-cycle
// rsp_valid pulse in RESP.
//
// Optional feature (compile-time macro BUS_ARB_TIMEOUT_EN):
//   When defined, ISSUE gives up after TIMEOUT_CYCLES cycles without m_ready
//   and answers with rsp_err=1, rsp_rdata=0. When undefined, ISSUE waits
//   indefinitely and rsp_err is tied low.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-requester handshake (req_ready is one-hot or zero)
//   req_write         per-requester write flag (1=write, 0=read)
//   req_addr/wdata    packed per-requester address / write data
//   rsp_valid         one-cycle response pulse to the granted requester
//   rsp_rdata/err     shared response data / error flag
//   m_*               downstream bus (m_rdata sampled on m_valid & m_ready)
//   grant_id          index of the current / last granted requester
// ---------------------------------------------------------------------------
module bus_rr_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    localparam int unsigned GNT_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_write,
    output logic [ADDR_W-1:0]          m_addr,
    output logic [DATA_W-1:0]          m_wdata,
    input  logic [DATA_W-1:0]          m_rdata,
    output logic [GNT_W-1:0]           grant_id
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic [GNT_W-1:0]  last_grant_q, last_grant_d;
    logic [GNT_W-1:0]  grant_id_q,   grant_id_d;
    logic              write_q,      write_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic [DATA_W-1:0] rsp_rdata_q,  rsp_rdata_d;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]  wait_cnt_q,   wait_cnt_d;
    logic              rsp_err_q,    rsp_err_d;
`endif

    // Round-robin pick: first set req_valid bit searching upward from
    // last_grant+1, wrapping modulo NUM_REQ. last_grant itself is checked
    // last, so a lone requester can still win back-to-back.
    logic [GNT_W-1:0]   sel;
    logic               sel_found;
    int unsigned        rr_idx;
    logic [NUM_REQ-1:0] rr_shift;

    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        rr_idx    = 0;
        rr_shift  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            rr_idx   = (32'(last_grant_q) + i) % NUM_REQ;
            rr_shift = req_valid >> rr_idx;
            if (!sel_found && rr_shift[0]) begin
                sel_found = 1'b1;
                sel       = GNT_W'(rr_idx);
            end
        end
    end

    // Selected requester's payload
    logic [NUM_REQ-1:0] sel_write_vec;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    always_comb begin
        sel_write_vec = req_write >> sel;
        sel_addr      = ADDR_W'(req_addr  >> (32'(sel) * ADDR_W));
        sel_wdata     = DATA_W'(req_wdata >> (32'(sel) * DATA_W));
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rsp_rdata_d  = rsp_rdata_q;
        req_ready    = '0;
`ifdef BUS_ARB_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        rsp_err_d    = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    req_ready  = NUM_REQ'(1) << sel;
                    write_d    = sel_write_vec[0];
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    grant_id_d = sel;
                    state_d    = ST_ISSUE;
`ifdef BUS_ARB_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end
            ST_ISSUE: begin
                if (m_ready) begin
                    rsp_rdata_d = write_q ? '0 : m_rdata;
                    state_d     = ST_RESP;
`ifdef BUS_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Terminal wait cycle without handshake: give up.
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wait_cnt_d  = wait_cnt_q + 1'b1;
`endif
                end
            end
            ST_RESP: begin
                last_grant_d = grant_id_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp_rdata_q  <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            wait_cnt_q   <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rsp_rdata_q  <= rsp_rdata_d;
`ifdef BUS_ARB_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    // Outputs decode straight from state so reset drops them asynchronously.
    assign m_valid   = (state_q == ST_ISSUE);
    assign m_write   = write_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign rsp_valid = (state_q == ST_RESP) ? (NUM_REQ'(1) << grant_id_q) : '0;
    assign rsp_rdata = rsp_rdata_q;
    assign grant_id  = grant_id_q;
`ifdef BUS_ARB_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_rr_arbiter
//
// Directed bench for bus_rr_arbiter (NUM_REQ=4, 32-bit bus, TIMEOUT_CYCLES=8).
// A vector table drives complete single transactions with hand-computed
// grants; hand-written sequences cover stall, reset in ISSUE and, when
// BUS_ARB_TIMEOUT_EN is defined, the timeout paths.
// ---------------------------------------------------------------------------
module tb_bus_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              m_valid;
    logic              m_ready;
    logic              m_write;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        grant_id;

    always #5 clk = ~clk;

    bus_rr_arbiter #(
        .NUM_REQ       (N),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_write  (m_write),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .grant_id (grant_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic         write;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [31:0]  rdata;
        int unsigned  gnt;
    } vec_t;

    vec_t vecs[16];

    // Granted requester gets base addr/wdata; every other requester gets a
    // distinct decoy value so a wrong mux select is visible.
    task automatic drive_payload(input int unsigned gnt, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic wr);
        for (int r = 0; r < int'(N); r++) begin
            req_addr[r*AW +: AW]  = (r == int'(gnt)) ? addr  : (~addr ^ 32'(r));
            req_wdata[r*DW +: DW] = (r == int'(gnt)) ? wdata : (~wdata ^ 32'(r << 4));
            req_write[r]          = (r == int'(gnt)) ? wr    : ~wr;
        end
    endtask

    // One complete transaction with m_ready=1: accept, issue, respond.
    task automatic run_vec(input vec_t v, input int idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << v.gnt;
        @(negedge clk);
        req_valid = v.valid;
        drive_payload(v.gnt, v.addr, v.wdata, v.write);
        m_ready = 1'b1;
        m_rdata = v.rdata;
        #1;
        chk($sformatf("v%0d req_ready", idx), 64'(req_ready), 64'(onehot));
        @(negedge clk);
        // Payload changes after acceptance must not reach the bus.
        req_valid = '0;
        req_addr  = ~req_addr;
        req_wdata = ~req_wdata;
        req_write = ~req_write;
        #1;
        chk($sformatf("v%0d m_valid", idx), 64'(m_valid), 64'(1));
        chk($sformatf("v%0d m_addr", idx), 64'(m_addr), 64'(v.addr));
        chk($sformatf("v%0d m_write", idx), 64'(m_write), 64'(v.write));
        if (v.write)
            chk($sformatf("v%0d m_wdata", idx), 64'(m_wdata), 64'(v.wdata));
        chk($sformatf("v%0d grant_id", idx), 64'(grant_id), 64'(v.gnt));
        @(negedge clk);
        #1;
        chk($sformatf("v%0d rsp_valid", idx), 64'(rsp_valid), 64'(onehot));
        chk($sformatf("v%0d rsp_rdata", idx), 64'(rsp_rdata), 64'(v.write ? 32'h0 : v.rdata));
        chk($sformatf("v%0d rsp_err", idx), 64'(rsp_err), 64'(0));
        chk($sformatf("v%0d m_valid_off", idx), 64'(m_valid), 64'(0));
    endtask

    initial begin
        int cnt;

        // After reset last_grant=3: all-requesting fairness yields 0,1,2,3,...
        for (int i = 0; i < 12; i++) begin
            vecs[i].valid = 4'b1111;
            vecs[i].write = (i % 3 == 1);
            vecs[i].addr  = 32'h1000_0000 + 32'(i * 16);
            vecs[i].wdata = 32'hA5A5_0000 + 32'(i);
            vecs[i].rdata = 32'h1111_0000 + 32'(i * 257);
            vecs[i].gnt   = i % 4;
        end
        // last=3: single read from requester 2
        vecs[12] = '{4'b0100, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2};
        // last=2: requester 3 write
        vecs[13] = '{4'b1000, 1'b1, 32'h0000_0300, 32'h1234_5678, 32'hFFFF_FFFF, 3};
        // last=3: 0101 wraps to requester 0, then requester 2
        vecs[14] = '{4'b0101, 1'b0, 32'h0000_0400, 32'h0, 32'h0BAD_F00D, 0};
        vecs[15] = '{4'b0101, 1'b0, 32'h0000_0500, 32'h0, 32'h7777_8888, 2};

        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        m_ready   = 1'b0;
        m_rdata   = '0;

        // Reset values
        #12;
        chk("rst m_valid", 64'(m_valid), 64'(0));
        chk("rst rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst req_ready", 64'(req_ready), 64'(0));
        chk("rst grant_id", 64'(grant_id), 64'(0));
        chk("rst rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst m_addr", 64'(m_addr), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Idle with no requests: nothing granted, nothing issued (last=2)
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("idle req_ready", 64'(req_ready), 64'(0));
            chk("idle m_valid", 64'(m_valid), 64'(0));
        end

        // Stall: write from requester 0, m_ready low for 5 ISSUE cycles
        @(negedge clk);
        req_valid = 4'b0001;
        drive_payload(0, 32'h20, 32'h55AA_55AA, 1'b1);
        m_ready = 1'b0;
        m_rdata = 32'hFFFF_0000;
        #1;
        chk("stall accept", 64'(req_ready), 64'(4'b0001));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            #1;
            chk($sformatf("stall%0d m_valid", c), 64'(m_valid), 64'(1));
            chk($sformatf("stall%0d m_addr", c), 64'(m_addr), 64'(32'h20));
            chk($sformatf("stall%0d m_wdata", c), 64'(m_wdata), 64'(32'h55AA_55AA));
            chk($sformatf("stall%0d m_write", c), 64'(m_write), 64'(1));
            chk($sformatf("stall%0d req_ready", c), 64'(req_ready), 64'(0));
            chk($sformatf("stall%0d rsp_valid", c), 64'(rsp_valid), 64'(0));
        end
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        chk("stall hs m_valid", 64'(m_valid), 64'(1));
        @(negedge clk);
        req_valid = '0;
        m_ready   = 1'b0;
        #1;
        chk("stall rsp_valid", 64'(rsp_valid), 64'(4'b0001));
        chk("stall rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("stall rsp_err", 64'(rsp_err), 64'(0));

        // Reset during ISSUE (last=0, so 0100 grants requester 2)
        @(negedge clk);
        req_valid = 4'b0100;
        drive_payload(2, 32'h40, 32'h0, 1'b0);
        m_rdata = 32'h3333_4444;
        #1;
        chk("rstiss accept", 64'(req_ready), 64'(4'b0100));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("rstiss m_valid", 64'(m_valid), 64'(1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstiss async m_valid", 64'(m_valid), 64'(0));
        chk("rstiss async rsp_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        #1;
        chk("rstiss grant_id", 64'(grant_id), 64'(0));
        chk("rstiss rsp_valid", 64'(rsp_valid), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        req_valid = 4'b1010;
        drive_payload(1, 32'h50, 32'h0, 1'b0);
        m_ready = 1'b1;
        #1;
        chk("post-rst no rsp", 64'(rsp_valid), 64'(0));
        chk("post-rst grant", 64'(req_ready), 64'(4'b0010));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("post-rst rsp_valid", 64'(rsp_valid), 64'(4'b0010));
        chk("post-rst rsp_rdata", 64'(rsp_rdata), 64'(32'h3333_4444));

`ifdef BUS_ARB_TIMEOUT_EN
        // Timeout with m_ready held low (last=1 -> requester 2)
        @(negedge clk);
        req_valid = 4'b0100;
        drive_payload(2, 32'h60, 32'h0, 1'b0);
        m_ready = 1'b0;
        m_rdata = 32'h9999_9999;
        #1;
        chk("to accept", 64'(req_ready), 64'(4'b0100));
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (!m_valid) break;
            cnt++;
        end
        chk("to m_valid cycles", 64'(cnt), 64'(8));
        chk("to rsp_valid", 64'(rsp_valid), 64'(4'b0100));
        chk("to rsp_err", 64'(rsp_err), 64'(1));
        chk("to rsp_rdata", 64'(rsp_rdata), 64'(0));

        // Handshake in the terminal cycle wins
        @(negedge clk);
        req_valid = 4'b0100;
        m_rdata   = 32'hCAFE_F00D;
        #1;
        chk("to2 accept", 64'(req_ready), 64'(4'b0100));
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (!m_valid) break;
            cnt++;
            if (cnt == 8) m_ready = 1'b1;
        end
        m_ready = 1'b0;
        chk("to2 m_valid cycles", 64'(cnt), 64'(8));
        chk("to2 rsp_valid", 64'(rsp_valid), 64'(4'b0100));
        chk("to2 rsp_err", 64'(rsp_err), 64'(0));
        chk("to2 rsp_rdata", 64'(rsp_rdata), 64'(32'hCAFE_F00D));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
